tpu_job_scheduler: RTL and testbench

Front-end scheduler for the 4x4 output-stationary TPU core. It accepts matrix-multiply jobs (K, M, N plus a tag) from two requesters and arbitrates between them round-robin. Accepted jobs are buffered in a 4-entry FIFO and launched on the TPU one at a time. Each job returns a completion record with status: ok, zero-dimension reject, or timeout.

---
 rtl/tpu_job_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_tpu_job_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_job_scheduler.sv
// tpu_job_scheduler: front-end for the 4x4 output-stationary TPU core.
// Two requesters are arbitrated round-robin into a small job FIFO. Jobs are
// launched one at a time and each one returns a completion record
// (ok / zero-dimension reject / timeout).
module tpu_job_scheduler #(
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [23:0] req0_dims,
    input  logic [3:0]  req0_tag,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [23:0] req1_dims,
    input  logic [3:0]  req1_tag,
    output logic        tpu_in_valid,
    output logic [7:0]  tpu_K,
    output logic [7:0]  tpu_M,
    output logic [7:0]  tpu_N,
    input  logic        tpu_busy,
    output logic        done_valid,
    output logic        done_req,
    output logic [3:0]  done_tag,
    output logic [1:0]  done_err,
    output logic        sched_idle
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 29;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ZERO    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               state_r;
    logic                 rr_ptr_r;
    logic [ENTRY_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_next_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push0_s;
    logic                 push1_s;
    logic                 push_s;
    logic                 pop_s;
    logic [ENTRY_W-1:0]   push_entry_s;
    logic [ENTRY_W-1:0]   head_s;
    logic                 head_zero_s;
    logic                 job_req_r;
    logic [3:0]           job_tag_r;
    logic [15:0]          timer_r;
    logic [15:0]          timer_inc_s;
    logic                 timeout_s;

    // Arbitration, FIFO bookkeeping and timer arithmetic.
    always_comb begin
        fifo_full_s  = (count_r == DEPTH_C);
        fifo_empty_s = (count_r == {CNT_W{1'b0}});
        // Ready is forced low while reset is asserted so every output reads 0.
        req0_ready   = rst_n && !fifo_full_s && (!rr_ptr_r || !req1_valid);
        req1_ready   = rst_n && !fifo_full_s && (rr_ptr_r || !req0_valid);
        push0_s      = req0_valid && req0_ready;
        push1_s      = req1_valid && req1_ready;
        push_s       = push0_s || push1_s;
        if (push1_s) begin
            push_entry_s = {1'b1, req1_tag, req1_dims};
        end else begin
            push_entry_s = {1'b0, req0_tag, req0_dims};
        end
        pop_s       = (state_r == ST_IDLE) && !fifo_empty_s;
        head_s      = fifo_mem_r[rd_ptr_r];
        head_zero_s = (head_s[23:16] == 8'd0) || (head_s[15:8] == 8'd0) ||
                      (head_s[7:0] == 8'd0);
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        // timer_r counts completed RUN cycles; timer_inc_s includes the
        // current one, so the timeout fires on the TIMEOUT_CYCLES-th RUN cycle.
        if (timer_r == 16'hFFFF) begin
            timer_inc_s = timer_r;
        end else begin
            timer_inc_s = timer_r + 16'd1;
        end
        timeout_s = (timer_inc_s >= TIMEOUT_CYCLES);
    end

    // Job FIFO storage, pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            rr_ptr_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
                // Priority moves to the requester that was not just served.
                rr_ptr_r             <= ~push1_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Job sequencing FSM with registered TPU launch and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            job_req_r    <= 1'b0;
            job_tag_r    <= 4'd0;
            timer_r      <= 16'd0;
            tpu_in_valid <= 1'b0;
            tpu_K        <= 8'd0;
            tpu_M        <= 8'd0;
            tpu_N        <= 8'd0;
            done_valid   <= 1'b0;
            done_req     <= 1'b0;
            done_tag     <= 4'd0;
            done_err     <= 2'b00;
            sched_idle   <= 1'b0;
        end else begin
            tpu_in_valid <= 1'b0;
            done_valid   <= 1'b0;
            // Next state is IDLE only from DONE, or from IDLE with nothing to pop.
            sched_idle   <= ((state_r == ST_DONE) ||
                             ((state_r == ST_IDLE) && fifo_empty_s)) &&
                            (count_next_s == {CNT_W{1'b0}});
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        job_req_r <= head_s[28];
                        job_tag_r <= head_s[27:24];
                        if (head_zero_s) begin
                            state_r    <= ST_DONE;
                            done_valid <= 1'b1;
                            done_req   <= head_s[28];
                            done_tag   <= head_s[27:24];
                            done_err   <= ERR_ZERO;
                        end else begin
                            state_r      <= ST_LAUNCH;
                            tpu_in_valid <= 1'b1;
                            tpu_K        <= head_s[23:16];
                            tpu_M        <= head_s[15:8];
                            tpu_N        <= head_s[7:0];
                        end
                    end
                end
                ST_LAUNCH: begin
                    timer_r <= 16'd0;
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    timer_r <= timer_inc_s;
                    if (!tpu_busy) begin
                        state_r    <= ST_DONE;
                        done_valid <= 1'b1;
                        done_req   <= job_req_r;
                        done_tag   <= job_tag_r;
                        done_err   <= ERR_OK;
                    end else if (timeout_s) begin
                        state_r    <= ST_DONE;
                        done_valid <= 1'b1;
                        done_req   <= job_req_r;
                        done_tag   <= job_tag_r;
                        done_err   <= ERR_TIMEOUT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Directed testbench for tpu_job_scheduler (TIMEOUT_CYCLES = 16).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_tpu_job_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [23:0] req0_dims;
    logic [3:0]  req0_tag;
    logic        req1_valid;
    logic        req1_ready;
    logic [23:0] req1_dims;
    logic [3:0]  req1_tag;
    logic        tpu_in_valid;
    logic [7:0]  tpu_K;
    logic [7:0]  tpu_M;
    logic [7:0]  tpu_N;
    logic        tpu_busy;
    logic        done_valid;
    logic        done_req;
    logic [3:0]  done_tag;
    logic [1:0]  done_err;
    logic        sched_idle;

    int checks     = 0;
    int errors     = 0;
    int launch_cnt = 0;
    int done_cnt   = 0;
    int lsnap;
    int dsnap;

    tpu_job_scheduler #(
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(16'd16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_dims   (req0_dims),
        .req0_tag    (req0_tag),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_dims   (req1_dims),
        .req1_tag    (req1_tag),
        .tpu_in_valid(tpu_in_valid),
        .tpu_K       (tpu_K),
        .tpu_M       (tpu_M),
        .tpu_N       (tpu_N),
        .tpu_busy    (tpu_busy),
        .done_valid  (done_valid),
        .done_req    (done_req),
        .done_tag    (done_tag),
        .done_err    (done_err),
        .sched_idle  (sched_idle)
    );

    always #5 clk = ~clk;

    // Count launch and completion pulses for "no pulse" windows.
    always @(negedge clk) begin
        if (tpu_in_valid === 1'b1) launch_cnt <= launch_cnt + 1;
        if (done_valid === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Called at a sample point; advances until a launch is seen or the bound expires.
    task automatic wait_launch(input int bound, input string name, input logic [31:0] exp_k);
        for (int i = 0; i < bound; i++) begin
            if (tpu_in_valid === 1'b1) break;
            tick();
            smp();
        end
        chk(name, tpu_in_valid, 1);
        chk({name, "_K"}, tpu_K, exp_k);
    endtask

    // Called at the launch sample point: busy low in the first RUN cycle,
    // completion record expected the following cycle.
    task automatic finish_job(input string name, input logic [31:0] exp_req, input logic [31:0] exp_tag);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tpu_busy   = 1'b0;
        smp();
        tick();
        tpu_busy = 1'b1;
        smp();
        chk({name, "_done_valid"}, done_valid, 1);
        chk({name, "_done_req"}, done_req, exp_req);
        chk({name, "_done_tag"}, done_tag, exp_tag);
        chk({name, "_done_err"}, done_err, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_dims  = 24'd0;
        req0_tag   = 4'd0;
        req1_valid = 1'b0;
        req1_dims  = 24'd0;
        req1_tag   = 4'd0;
        tpu_busy   = 1'b1;

        // ---- reset state ----
        tick(); tick(); smp();
        chk("rst_tpu_in_valid", tpu_in_valid, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_sched_idle", sched_idle, 0);
        chk("rst_tpu_K", tpu_K, 0);
        chk("rst_done_err", done_err, 0);
        tick(); req0_valid = 1'b1; smp();
        chk("rst_req0_ready", req0_ready, 0);
        tick(); req0_valid = 1'b0; rst_n = 1'b1; smp();
        chk("rel_req0_ready", req0_ready, 1);
        chk("rel_req1_ready", req1_ready, 1);
        tick(); smp();
        chk("rel_sched_idle", sched_idle, 1);

        // ---- single job: launch at t0+2, busy low at t0+12, done at t0+13 ----
        tick();
        req0_valid = 1'b1; req0_dims = 24'h080404; req0_tag = 4'd3;
        smp();
        chk("single_ready", req0_ready, 1);
        tick(); req0_valid = 1'b0; smp();
        chk("single_no_early_launch", tpu_in_valid, 0);
        chk("single_not_idle", sched_idle, 0);
        tick(); smp();
        chk("single_launch", tpu_in_valid, 1);
        chk("single_K", tpu_K, 8'd8);
        chk("single_M", tpu_M, 8'd4);
        chk("single_N", tpu_N, 8'd4);
        tick(); smp();
        chk("single_pulse_width", tpu_in_valid, 0);
        chk("single_K_held", tpu_K, 8'd8);
        repeat (9) tick();
        tpu_busy = 1'b0;
        smp();
        chk("single_no_early_done", done_valid, 0);
        tick(); tpu_busy = 1'b1; smp();
        chk("single_done_valid", done_valid, 1);
        chk("single_done_req", done_req, 0);
        chk("single_done_tag", done_tag, 3);
        chk("single_done_err", done_err, 0);
        tick(); smp();
        chk("single_done_pulse", done_valid, 0);
        chk("single_idle_after", sched_idle, 1);

        // ---- zero dimension: done two cycles after handshake, no launch ----
        tick();
        lsnap = launch_cnt;
        req1_valid = 1'b1; req1_dims = 24'h000404; req1_tag = 4'd9;
        smp();
        chk("zero_ready", req1_ready, 1);
        tick(); req1_valid = 1'b0; smp();
        chk("zero_no_early_done", done_valid, 0);
        tick(); smp();
        chk("zero_done_valid", done_valid, 1);
        chk("zero_done_req", done_req, 1);
        chk("zero_done_tag", done_tag, 9);
        chk("zero_done_err", done_err, 1);
        tick(); smp();
        chk("zero_done_pulse", done_valid, 0);
        tick();
        chk("zero_no_launch", launch_cnt, lsnap);

        // ---- contention: both valid for 4 cycles, rr starts at 0 ----
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_valid = 1'b1; req0_dims = 24'h010101; req0_tag = 4'd4;
            req1_valid = 1'b1; req1_dims = 24'h020202; req1_tag = 4'd5;
            smp();
            chk($sformatf("cont_ready0_%0d", i), req0_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("cont_ready1_%0d", i), req1_ready, (i % 2 == 1) ? 1 : 0);
            if (i == 2) begin
                chk("cont_launch0", tpu_in_valid, 1);
                chk("cont_launch0_K", tpu_K, 8'd1);
            end
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0; tpu_busy = 1'b0;
        smp();
        chk("cont_run0_K", tpu_K, 8'd1);
        tick(); tpu_busy = 1'b1; smp();
        chk("cont_done0_valid", done_valid, 1);
        chk("cont_done0_req", done_req, 0);
        chk("cont_done0_tag", done_tag, 4);
        for (int j = 1; j < 4; j++) begin
            tick(); smp();
            wait_launch(12, $sformatf("cont_launch%0d", j), (j % 2 == 1) ? 2 : 1);
            finish_job($sformatf("cont_job%0d", j), j % 2, (j % 2 == 1) ? 5 : 4);
        end

        // ---- full FIFO: six back-to-back req0 jobs ----
        for (int i = 0; i < 5; i++) begin
            tick();
            req0_valid = 1'b1; req0_dims = {8'(i + 1), 8'd2, 8'd2}; req0_tag = 4'(i);
            smp();
            chk($sformatf("full_ready_%0d", i), req0_ready, 1);
        end
        tick();
        req0_dims = {8'd6, 8'd2, 8'd2}; req0_tag = 4'd5;
        smp();
        chk("full_blocked_f5", req0_ready, 0);
        tick(); smp();
        chk("full_blocked_f6", req0_ready, 0);
        tick(); smp();
        chk("full_blocked_f7", req0_ready, 0);
        tick(); tpu_busy = 1'b0; smp();
        chk("full_blocked_f8", req0_ready, 0);
        tick(); tpu_busy = 1'b1; smp();
        chk("full_done0_valid", done_valid, 1);
        chk("full_done0_tag", done_tag, 0);
        chk("full_blocked_f9", req0_ready, 0);
        tick(); smp();
        chk("full_blocked_f10", req0_ready, 0);
        tick(); smp();
        chk("full_ready_after_pop", req0_ready, 1);
        chk("full_launch1", tpu_in_valid, 1);
        chk("full_launch1_K", tpu_K, 8'd2);
        finish_job("full_job1", 0, 1);
        for (int j = 2; j < 6; j++) begin
            tick(); smp();
            wait_launch(12, $sformatf("full_launch%0d", j), j + 1);
            finish_job($sformatf("full_job%0d", j), 0, j);
        end

        // ---- timeout: launch at L, err=10 done at L+17, next launch at L+19 ----
        tick();
        req0_valid = 1'b1; req0_dims = 24'h050505; req0_tag = 4'd7;
        smp();
        chk("to_ready_a", req0_ready, 1);
        tick(); req0_dims = 24'h060606; req0_tag = 4'd8; smp();
        chk("to_ready_b", req0_ready, 1);
        tick(); req0_valid = 1'b0; smp();
        chk("to_launch", tpu_in_valid, 1);
        chk("to_launch_K", tpu_K, 8'd5);
        repeat (16) tick();
        smp();
        chk("to_not_early", done_valid, 0);
        tick(); smp();
        chk("to_done_valid", done_valid, 1);
        chk("to_done_err", done_err, 2);
        chk("to_done_tag", done_tag, 7);
        chk("to_done_req", done_req, 0);
        tick(); smp();
        chk("to_no_launch_l18", tpu_in_valid, 0);
        tick(); smp();
        chk("to_next_launch_l19", tpu_in_valid, 1);
        chk("to_next_launch_K", tpu_K, 8'd6);
        finish_job("to_next_job", 0, 8);

        // ---- reset mid-RUN with two jobs queued ----
        tick();
        req0_valid = 1'b1; req0_dims = 24'h0A0A0A; req0_tag = 4'd1;
        smp();
        tick(); req0_dims = 24'h0B0B0B; req0_tag = 4'd2; smp();
        tick(); req0_dims = 24'h0C0C0C; req0_tag = 4'd3; smp();
        chk("rr_launch_first", tpu_in_valid, 1);
        tick(); req0_valid = 1'b0; smp();
        tick();
        lsnap = launch_cnt;
        dsnap = done_cnt;
        rst_n = 1'b0;
        smp();
        chk("rr_in_reset_idle", sched_idle, 0);
        chk("rr_in_reset_tpu_in_valid", tpu_in_valid, 0);
        chk("rr_in_reset_ready", req0_ready, 0);
        tick(); rst_n = 1'b1; smp();
        tick(); smp();
        chk("rr_idle_after_release", sched_idle, 1);
        repeat (5) begin
            tick(); smp();
        end
        tick();
        chk("rr_no_done", done_cnt, dsnap);
        chk("rr_no_launch", launch_cnt, lsnap);
        req0_valid = 1'b1; req0_dims = 24'h0D0E0F; req0_tag = 4'd6;
        smp();
        chk("rr_new_ready", req0_ready, 1);
        tick(); req0_valid = 1'b0; smp();
        chk("rr_new_no_early", tpu_in_valid, 0);
        tick(); smp();
        chk("rr_new_launch", tpu_in_valid, 1);
        chk("rr_new_K", tpu_K, 8'h0D);
        chk("rr_new_M", tpu_M, 8'h0E);
        chk("rr_new_N", tpu_N, 8'h0F);
        finish_job("rr_new_job", 0, 6);
        tick(); smp();
        chk("final_idle", sched_idle, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
